// File: rtl/bcd_step_counter_pkg.sv
// Shared digit constants and step-direction decode for the BCD step counter
// and the downstream 7-segment decoder.
package bcd_step_counter_pkg;

  localparam int                   DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0]   DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0]   DIGIT_MIN = 4'd0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_dir_e;

  // Simultaneous up and down presses cancel each other out.
  function automatic step_dir_e step_dir(input logic up, input logic down);
    step_dir_e dir;
    dir = STEP_HOLD;
    if (up && !down) begin
      dir = STEP_UP;
    end else if (down && !up) begin
      dir = STEP_DOWN;
    end
    return dir;
  endfunction

endpackage

// File: rtl/bcd_step_counter_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-window debouncer and
// a registered single-cycle rise pulse per debounced press.
module btn_debounce #(
  parameter int DEB_CNT = 120000,
  parameter int DEB_W   = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             rise_q, rise_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    level_dly_d = level_q;
    rise_d      = level_q & ~level_dly_q;
    // Any sample that agrees with the current level restarts the window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/bcd_step_counter.sv
// Single BCD digit driven by debounced up/down buttons, with wrap-around and
// one-cycle carry/borrow/step pulses for chaining a further digit.
module bcd_step_counter
  import bcd_step_counter_pkg::*;
#(
  parameter int DEB_CNT = 120000,
  parameter int DEB_W   = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry,
  output logic               borrow,
  output logic               step
);

  logic up_level, up_rise;
  logic down_level, down_rise;
  logic unused_levels;

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               step_q, step_d;

  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_up_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (up_level),
    .rise  (up_rise)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_down_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .level (down_level),
    .rise  (down_rise)
  );

  assign unused_levels = up_level ^ down_level;

  always_comb begin
    digit_d  = digit_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    step_d   = 1'b0;
    // An out-of-range code is recovered silently rather than stepped from.
    if (digit_q > DIGIT_MAX) begin
      digit_d = DIGIT_MIN;
    end else begin
      case (step_dir(up_rise, down_rise))
        STEP_UP: begin
          step_d = 1'b1;
          if (digit_q == DIGIT_MAX) begin
            digit_d = DIGIT_MIN;
            carry_d = 1'b1;
          end else begin
            digit_d = digit_q + DIGIT_W'(1);
          end
        end
        STEP_DOWN: begin
          step_d = 1'b1;
          if (digit_q == DIGIT_MIN) begin
            digit_d  = DIGIT_MAX;
            borrow_d = 1'b1;
          end else begin
            digit_d = digit_q - DIGIT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q  <= DIGIT_MIN;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      step_q   <= step_d;
    end
  end

  assign digit  = digit_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign step   = step_q;

endmodule
